// File: rtl/operand_feeder_pkg.sv
// Shared types and sizing helpers for the operand feeder FIFO.
package operand_feeder_pkg;

  localparam int FEEDER_WIDTH = 5;

  typedef struct packed {
    logic [FEEDER_WIDTH-1:0] in1;
    logic [FEEDER_WIDTH-1:0] in2;
    logic                    orr;
    logic                    andr;
  } feeder_entry_t;

  // Pointer width; a 1-entry FIFO would still need one bit to index.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/operand_feeder_mem.sv
// DEPTH-entry register storage: one write port, one asynchronous read port.
module operand_feeder_mem
  import operand_feeder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = $bits(feeder_entry_t),
  parameter int PW      = ptr_w(DEPTH)
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [PW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  // No reset: the top masks outputs whenever the FIFO is empty.
  logic [DEPTH-1:0][ENTRY_W-1:0] mem;

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/operand_feeder.sv
// Operand-pair FIFO feeding the reduction block; reductions of in1 are taken at enqueue.
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [WIDTH-1:0]           push_in1,
  input  logic [WIDTH-1:0]           push_in2,
  output logic                       handshake_valid,
  input  logic                       handshake_ready,
  output logic [WIDTH-1:0]           in1,
  output logic [WIDTH-1:0]           in2,
  output logic                       orr_out,
  output logic                       andr_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           xfer_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int OW = occ_w(DEPTH);

  // Local entry type so WIDTH may differ from the package default.
  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             orr;
    logic             andr;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    occ_q;
  logic [CNT_W-1:0] xfer_cnt;
  entry_t           wr_entry, rd_entry;
  logic             push, pop;

  assign push_ready      = (occ_q != OW'(DEPTH)) && !RESET;
  assign handshake_valid = (occ_q != '0);
  assign push            = push_valid && push_ready;
  assign pop             = handshake_valid && handshake_ready;

  assign wr_entry.in1  = push_in1;
  assign wr_entry.in2  = push_in2;
  assign wr_entry.orr  = |push_in1;
  assign wr_entry.andr = &push_in1;

  operand_feeder_mem #(
    .DEPTH  (DEPTH),
    .ENTRY_W(ENTRY_W),
    .PW     (PW)
  ) u_mem (
    .CLK  (CLK),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .raddr(rd_ptr),
    .rdata(rd_entry)
  );

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ_q    <= '0;
      xfer_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign in1        = handshake_valid ? rd_entry.in1  : '0;
  assign in2        = handshake_valid ? rd_entry.in2  : '0;
  assign orr_out    = handshake_valid ? rd_entry.orr  : 1'b0;
  assign andr_out   = handshake_valid ? rd_entry.andr : 1'b0;
  assign occupancy  = occ_q;
  assign xfer_count = xfer_cnt;

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder: driver queues expected entries, monitor checks pops.
module tb_operand_feeder;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        push_valid = 1'b1;
  logic        push_ready;
  logic [4:0]  push_in1 = 5'h1F;
  logic [4:0]  push_in2 = 5'h00;
  logic        handshake_valid;
  logic        handshake_ready = 1'b0;
  logic [4:0]  in1, in2;
  logic        orr_out, andr_out;
  logic [2:0]  occupancy;
  logic [15:0] xfer_count;

  always #5 clk = ~clk;

  operand_feeder #(.WIDTH(5), .DEPTH(4), .CNT_W(16)) dut (
    .CLK            (clk),
    .RESET          (RESET),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_in1       (push_in1),
    .push_in2       (push_in2),
    .handshake_valid(handshake_valid),
    .handshake_ready(handshake_ready),
    .in1            (in1),
    .in2            (in2),
    .orr_out        (orr_out),
    .andr_out       (andr_out),
    .occupancy      (occupancy),
    .xfer_count     (xfer_count)
  );

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic       o;
    logic       n;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp = '0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a vector with its hand-computed reductions.
  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic o, input logic n);
    push_valid = v;
    push_in1   = a;
    push_in2   = b;
    cur_exp    = '{a: a, b: b, o: o, n: n};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: records accepted pushes and checks every pop against the queue.
  always @(negedge clk) begin
    if (!RESET) begin
      if (handshake_valid && handshake_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pop_in1", 32'(in1), 32'(e.a));
          chk("pop_in2", 32'(in2), 32'(e.b));
          chk("pop_orr", 32'(orr_out), 32'(e.o));
          chk("pop_andr", 32'(andr_out), 32'(e.n));
        end
      end
      if (!handshake_valid)
        chk("empty_mask", 32'({in1, in2, orr_out, andr_out}), 32'(0));
      if (push_valid && push_ready) sb.push_back(cur_exp);
    end
  end

  logic [4:0] s_in1 [10] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09};
  logic [4:0] s_in2 [10] = '{5'h09, 5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00};
  logic       s_orr [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // Reset held 3 cycles with push_valid high.
    repeat (3) begin
      step();
      chk("rst_push_ready", 32'(push_ready), 32'(0));
      chk("rst_valid", 32'(handshake_valid), 32'(0));
      chk("rst_outs", 32'({in1, in2, orr_out, andr_out}), 32'(0));
      chk("rst_occ", 32'(occupancy), 32'(0));
    end
    RESET = 1'b0;
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    step();
    chk("post_rst_ready", 32'(push_ready), 32'(1));
    chk("post_rst_occ", 32'(occupancy), 32'(0));
    chk("post_rst_xfer", 32'(xfer_count), 32'(0));

    // Single transfer with a 3-cycle hold.
    drive(1'b1, 5'h1F, 5'h0A, 1'b1, 1'b1);
    step();
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    repeat (4) begin
      chk("single_valid", 32'(handshake_valid), 32'(1));
      chk("single_data", 32'({in1, in2, orr_out, andr_out}), 32'({5'h1F, 5'h0A, 1'b1, 1'b1}));
      step();
    end
    handshake_ready = 1'b1;
    step();
    handshake_ready = 1'b0;
    chk("single_xfer", 32'(xfer_count), 32'(1));
    chk("single_empty", 32'(handshake_valid), 32'(0));
    chk("single_occ", 32'(occupancy), 32'(0));

    // Fill to full.
    drive(1'b1, 5'h00, 5'h10, 1'b0, 1'b0); step();
    drive(1'b1, 5'h01, 5'h11, 1'b1, 1'b0); step();
    drive(1'b1, 5'h02, 5'h12, 1'b1, 1'b0); step();
    drive(1'b1, 5'h03, 5'h13, 1'b1, 1'b0); step();
    drive(1'b1, 5'h04, 5'h14, 1'b1, 1'b0);
    chk("full_ready", 32'(push_ready), 32'(0));
    chk("full_occ", 32'(occupancy), 32'(4));
    chk("full_head", 32'({in1, in2, orr_out, andr_out}), 32'({5'h00, 5'h10, 1'b0, 1'b0}));
    step();
    chk("full_no_push", 32'(occupancy), 32'(4));

    // Full with simultaneous pop: pop wins, push lands next cycle.
    handshake_ready = 1'b1;
    step();
    chk("fullpop_occ", 32'(occupancy), 32'(3));
    chk("fullpop_ready", 32'(push_ready), 32'(1));
    step();
    chk("fullpop_next_occ", 32'(occupancy), 32'(3));
    chk("fullpop_next_head", 32'(in1), 32'(5'h02));
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    repeat (3) step();
    handshake_ready = 1'b0;
    chk("drain_occ", 32'(occupancy), 32'(0));
    chk("drain_xfer", 32'(xfer_count), 32'(6));

    // Clean restart, then streaming through the wrap.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    sb.delete();
    handshake_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, s_in1[i], s_in2[i], s_orr[i], 1'b0);
      step();
      chk("stream_occ", 32'(occupancy), 32'(1));
    end
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    step();
    handshake_ready = 1'b0;
    chk("stream_xfer", 32'(xfer_count), 32'(10));
    chk("stream_occ_end", 32'(occupancy), 32'(0));

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFF;
    #1;
    release dut.xfer_cnt;
    step();
    chk("preload_xfer", 32'(xfer_count), 32'(16'hFFFF));
    drive(1'b1, 5'h15, 5'h0E, 1'b1, 1'b0);
    step();
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    handshake_ready = 1'b1;
    step();
    handshake_ready = 1'b0;
    chk("wrap_xfer", 32'(xfer_count), 32'(0));

    // Mid-operation reset with two entries held.
    drive(1'b1, 5'h07, 5'h18, 1'b1, 1'b0); step();
    drive(1'b1, 5'h1E, 5'h01, 1'b1, 1'b0); step();
    drive(1'b1, 5'h10, 5'h0F, 1'b1, 1'b0); step();
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    handshake_ready = 1'b1;
    step();
    chk("pre_rst_occ", 32'(occupancy), 32'(2));
    chk("pre_rst_xfer", 32'(xfer_count), 32'(1));
    RESET = 1'b1;
    drive(1'b1, 5'h0C, 5'h03, 1'b1, 1'b0);
    step();
    chk("mid_rst_valid", 32'(handshake_valid), 32'(0));
    chk("mid_rst_occ", 32'(occupancy), 32'(0));
    chk("mid_rst_xfer", 32'(xfer_count), 32'(0));
    chk("mid_rst_outs", 32'({in1, in2, orr_out, andr_out}), 32'(0));
    sb.delete();
    RESET = 1'b0;
    handshake_ready = 1'b0;
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    step();
    chk("after_rst_ready", 32'(push_ready), 32'(1));
    chk("after_rst_occ", 32'(occupancy), 32'(0));

    step();
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
# operand_feeder

Upstream stage of the RTL reduction block. Accepts operand pairs (`in1`, `in2`) over a ready/valid input channel and buffers them in a DEPTH-entry FIFO. Presents the head entry on the `handshake_ready`/`handshake_valid` channel that the RTL block and its bound monitor observe. Computes the OR-reduction and AND-reduction of `in1` at enqueue time, stores them with the entry, and maintains a wrapping transfer counter for coverage.

## Interface
- `WIDTH`, 5: operand width in bits; must be ≥ 1.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16: width of the transfer counter.

- `CLK`  input  1  single clock; all state updates on posedge.
- `RESET`  input  1  synchronous, active-high reset.
- `push_valid`  input  1  upstream offers an operand pair.
- `push_ready`  output  1  feeder can accept an entry this cycle.
- `push_in1`  input  WIDTH  first operand.
- `push_in2`  input  WIDTH  second operand.
- `handshake_valid`  output  1  head entry is valid.
- `handshake_ready`  input  1  downstream accepts the head entry.
- `in1`  output  WIDTH  head `in1`; 0 when empty.
- `in2`  output  WIDTH  head `in2`; 0 when empty.
- `orr_out`  output  1  `|in1` of the head entry; 0 when empty.
- `andr_out`  output  1  `&in1` of the head entry; 0 when empty.
- `occupancy`  output  $clog2(DEPTH+1)  number of stored entries.
- `xfer_count`  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

## Operation
- **Push.** A push occurs when `push_valid && push_ready` at a posedge.
  - The entry stores {`push_in1`, `push_in2`, `|push_in1`, `&push_in1`} at `wr_ptr`.
  - `wr_ptr` then increments and wraps at DEPTH.
- **Pop.** A pop occurs when `handshake_valid && handshake_ready` at a posedge.
  - `rd_ptr` increments and wraps at DEPTH.
  - `xfer_count` increments by 1 and wraps from 2^CNT_W−1 to 0.
- **Ready/valid derivation.**
  - `push_ready = (occupancy != DEPTH) && !RESET`. It depends only on registered state, not on `handshake_ready`.
  - `handshake_valid = (occupancy != 0)`.
- **Output masking.** `in1`, `in2`, `orr_out` and `andr_out` are forced to 0 whenever `handshake_valid` is 0. No stale data is visible on an empty FIFO.
- **Occupancy update.**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
  - Neither: unchanged.
- **Full.** `push_ready` = 0, so no push is possible. A pop in that cycle still occurs, and `push_ready` rises the next cycle. There is no same-cycle pass-through.
- **Empty.** No pop is possible. A push makes the entry visible the next cycle. There is no combinational bypass from `push_*` to outputs.
- **Wrap-around.** Pointers are $clog2(DEPTH) bits. Full and empty are distinguished by `occupancy`, not by pointer equality.
- **Stability.** While `handshake_valid && !handshake_ready`, the head outputs hold their values. The FIFO never retracts valid.
- **Reset.** `RESET` sampled high at a posedge has these effects:
  - `occupancy`, both pointers and `xfer_count` go to 0.
  - Entries are discarded. Storage contents need not be cleared because outputs are masked.
  - A push or pop coincident with reset is ignored.

## Timing
- Reset values: `push_ready` 0 while `RESET` is high, then 1. `handshake_valid` 0. `in1`/`in2` 0. `orr_out`/`andr_out` 0. `occupancy` 0. `xfer_count` 0.
- Latency: a push at posedge N gives `handshake_valid` = 1 and the data visible after posedge N (cycle N+1).
- Throughput: one push and one pop per cycle in steady state. With downstream always ready, a continuous stream sustains 1 entry/cycle at occupancy 1.
- All outputs are functions of registers only, except `push_ready`, which also gates on `RESET`. There is no combinational path from `handshake_ready` or `push_valid` to any output.

## Structure
- Package `operand_feeder_pkg` holds:
  - `typedef struct packed {logic [WIDTH-1:0] in1, in2; logic orr, andr;} feeder_entry_t`, with a parameterised-width default of 5.
  - Pointer/occupancy width helper constants.
- One sub-module, `operand_feeder_mem`:
  - DEPTH × entry register array.
  - One write port and one asynchronous read port.
  - No reset on storage.
- Top level holds the pointers, occupancy, `xfer_count`, the handshake logic and the output masking.

## Test plan
- **Reset.** Assert `RESET` 3 cycles with `push_valid` = 1 → throughout reset, `push_ready` = 0, `handshake_valid` = 0 and all outputs 0. After release, `push_ready` = 1 and `occupancy` = 0.
- **Single transfer.** Push `in1` = 5'h1F, `in2` = 5'h0A with `handshake_ready` = 0 → next cycle `handshake_valid` = 1, `in1` = 1F, `in2` = 0A, `orr_out` = 1, `andr_out` = 1. Hold 3 cycles with stable outputs, then raise ready → pop, `xfer_count` = 1, empty.
- **Fill to full.** Push 5'h00, 5'h01, 5'h02, 5'h03 with ready = 0 → after the 4th push, `push_ready` = 0 and `occupancy` = 4. The head `5'h00` shows `orr_out` = 0 and `andr_out` = 0. A 5th `push_valid` is not accepted.
- **Full with simultaneous pop.** At full, assert `handshake_ready` and `push_valid` together → the pop occurs and the push does not; `occupancy` = 3. Next cycle the push is accepted and `occupancy` stays 3.
- **Streaming and wrap.** Push 10 consecutive values 0..9 with ready = 1 every cycle → values pop in order. Pointers wrap past DEPTH, `occupancy` never exceeds 1, `xfer_count` = 10.
- **Counter wrap and mid-operation reset.**
  - Preload `xfer_count` to 16'hFFFF via forced stimulus, then pop once → `xfer_count` = 0.
  - Assert `RESET` with `occupancy` = 2 → next cycle `handshake_valid` = 0, `occupancy` = 0, `xfer_count` = 0.
